// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD complementer.
// Imported by the interface, the per-digit complement cell and the top.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_NINE = 4'd9;
    localparam logic [4:0] BCD_TEN  = 5'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/bcd_complement_seq_if.sv
// Operand/result handshake bundle for bcd_complement_seq.
// out_err exists only when BCD_CHECK_EN is defined.
interface bcd_complement_seq_if #(
    parameter int DIGITS = 4
);
    import bcd_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   in_bcd;
    logic                  in_mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  out_carry;
`ifdef BCD_CHECK_EN
    logic                  out_err;
`endif

    // master is the operand producer / result consumer, slave is the complementer
    modport master (
        output in_valid, in_bcd, in_mode, out_ready,
`ifdef BCD_CHECK_EN
        input  out_err,
`endif
        input  in_ready, out_valid, out_bcd, out_carry
    );

    modport slave (
        input  in_valid, in_bcd, in_mode, out_ready,
`ifdef BCD_CHECK_EN
        output out_err,
`endif
        output in_ready, out_valid, out_bcd, out_carry
    );

endinterface

// File: rtl/bcd_digit_comp.sv
// Combinational single-digit nine's/ten's complement cell with carry in/out.
// The invalid-digit flag is only built when BCD_CHECK_EN is defined.
module bcd_digit_comp
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    input  logic       carry_in,
    input  logic       mode,
    output bcd_digit_t result,
    output logic       carry_out
`ifdef BCD_CHECK_EN
    ,
    output logic       invalid
`endif
);

    logic [4:0] sum;

    // Non-BCD digits simply wrap modulo 16 through the same arithmetic.
    always_comb begin
        sum = {1'b0, BCD_NINE - digit} + {4'b0, carry_in & mode};
        if (sum == BCD_TEN) begin
            result    = '0;
            carry_out = 1'b1;
        end else begin
            result    = sum[3:0];
            carry_out = 1'b0;
        end
    end

`ifdef BCD_CHECK_EN
    assign invalid = (digit > BCD_NINE);
`endif

endmodule

// File: rtl/bcd_complement_seq.sv
// Multi-digit BCD nine's/ten's complementer, one digit per cycle LSD first.
// Optional input-digit checking with out_err is enabled by defining BCD_CHECK_EN.
module bcd_complement_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_complement_seq_if.slave  bus
);

    localparam int             IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0]  LAST = IW'(DIGITS - 1);

    state_t                state;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   operand;
    logic                  mode_q;
    logic                  carry;
    logic [4*DIGITS-1:0]   result_q;
    logic                  carry_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    bcd_digit_t            cur_digit;
    bcd_digit_t            res_digit;
    logic                  dc_carry;
`ifdef BCD_CHECK_EN
    logic                  invalid;
    logic                  err_q;
`endif

    assign cur_digit = operand[4*idx +: 4];

    bcd_digit_comp u_digit (
        .digit     (cur_digit),
        .carry_in  (carry),
        .mode      (mode_q),
        .result    (res_digit),
`ifdef BCD_CHECK_EN
        .invalid   (invalid),
`endif
        .carry_out (dc_carry)
    );

    // out_valid rises one cycle after the last digit lands, so results are settled
    // for a full cycle before they are presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            operand     <= '0;
            mode_q      <= 1'b0;
            carry       <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef BCD_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        operand    <= bus.in_bcd;
                        mode_q     <= bus.in_mode;
                        carry      <= bus.in_mode;
                        idx        <= '0;
                        result_q   <= '0;
                        carry_q    <= 1'b0;
                        in_ready_q <= 1'b0;
`ifdef BCD_CHECK_EN
                        err_q      <= 1'b0;
`endif
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    result_q[4*idx +: 4] <= res_digit;
                    carry                <= dc_carry;
`ifdef BCD_CHECK_EN
                    err_q                <= err_q | invalid;
`endif
                    if (idx == LAST) begin
                        carry_q <= dc_carry;
                        state   <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bcd   = result_q;
    assign bus.out_carry = carry_q;
`ifdef BCD_CHECK_EN
    assign bus.out_err   = err_q;
`endif

endmodule

// File: tb/tb_bcd_complement_seq.sv
// Directed self-checking bench for bcd_complement_seq with DIGITS=4.
// The out_err scenario is compiled only when BCD_CHECK_EN is defined.
module tb_bcd_complement_seq;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bcd_complement_seq_if #(.DIGITS(4)) bus ();

    bcd_complement_seq #(.DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accept one operand, scramble the inputs, then wait (bounded) for out_valid.
    task automatic do_op(input logic [15:0] bcd, input logic mode, output int lat, output logic ok);
        int w;
        ok  = 1'b1;
        lat = 0;
        w   = 0;
        while (!bus.in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (!bus.in_ready) begin
            ok = 1'b0;
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_bcd   = bcd;
        bus.in_mode  = mode;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_bcd   = 16'hFFFF;
        bus.in_mode  = ~mode;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) ok = 1'b0;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++;
        if (bus.out_bcd !== 16'h0000 || bus.out_carry !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_out_bcd got %h/%b want 0000/0", bus.out_bcd, bus.out_carry);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_nines();
        logic [15:0] ops [2] = '{16'h1234, 16'h0000};
        logic [15:0] exp [2] = '{16'h8765, 16'h9999};
        int lat;
        logic ok;
        for (int i = 0; i < 2; i++) begin
            do_op(ops[i], 1'b0, lat, ok);
            checks++;
            if (!ok || lat != 5) begin errors++; $display("[TB] FAIL nines_latency[%0d] got %0d want 5", i, lat); end
            checks++;
            if (bus.out_bcd !== exp[i] || bus.out_carry !== 1'b0) begin
                errors++; $display("[TB] FAIL nines_result[%0d] got %h/%b want %h/0", i, bus.out_bcd, bus.out_carry, exp[i]);
            end
            consume();
        end
    endtask

    task automatic test_tens();
        logic [15:0] ops [4] = '{16'h1234, 16'h0990, 16'h0000, 16'h0001};
        logic [15:0] exp [4] = '{16'h8766, 16'h9010, 16'h0000, 16'h9999};
        logic        cy  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int lat;
        logic ok;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], 1'b1, lat, ok);
            checks++;
            if (!ok || lat != 5) begin errors++; $display("[TB] FAIL tens_latency[%0d] got %0d want 5", i, lat); end
            checks++;
            if (bus.out_bcd !== exp[i] || bus.out_carry !== cy[i]) begin
                errors++; $display("[TB] FAIL tens_result[%0d] got %h/%b want %h/%b", i, bus.out_bcd, bus.out_carry, exp[i], cy[i]);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic ok;
        do_op(16'h1234, 1'b0, lat, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL bp_timeout got no out_valid want out_valid"); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_bcd !== 16'h8765 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold[%0d] got v=%b bcd=%h rdy=%b want v=1 bcd=8765 rdy=0",
                         i, bus.out_valid, bus.out_bcd, bus.in_ready);
            end
        end
        consume();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL bp_release got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_midrun_reset();
        int lat;
        logic ok;
        bus.in_valid = 1'b1;
        bus.in_bcd   = 16'h5678;
        bus.in_mode  = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_bcd !== 16'h0000 || bus.out_carry !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrun_reset got rdy=%b v=%b bcd=%h cy=%b want rdy=1 v=0 bcd=0000 cy=0",
                     bus.in_ready, bus.out_valid, bus.out_bcd, bus.out_carry);
        end
        do_op(16'h0001, 1'b1, lat, ok);
        checks++;
        if (!ok || bus.out_bcd !== 16'h9999 || bus.out_carry !== 1'b0) begin
            errors++; $display("[TB] FAIL after_reset_op got %h/%b want 9999/0", bus.out_bcd, bus.out_carry);
        end
        consume();
    endtask

`ifdef BCD_CHECK_EN
    task automatic test_bcd_check();
        int lat;
        logic ok;
        do_op(16'h12A4, 1'b0, lat, ok);
        checks++;
        if (!ok || bus.out_err !== 1'b1 || bus.out_bcd !== 16'h87F5) begin
            errors++; $display("[TB] FAIL err_set got err=%b bcd=%h want err=1 bcd=87f5", bus.out_err, bus.out_bcd);
        end
        consume();
        do_op(16'h0001, 1'b0, lat, ok);
        checks++;
        if (!ok || bus.out_err !== 1'b0 || bus.out_bcd !== 16'h9998) begin
            errors++; $display("[TB] FAIL err_clear got err=%b bcd=%h want err=0 bcd=9998", bus.out_err, bus.out_bcd);
        end
        consume();
    endtask
`endif

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_bcd    = '0;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_nines();
        test_tens();
        test_backpressure();
        test_midrun_reset();
`ifdef BCD_CHECK_EN
        test_bcd_check();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
